top_level_hamming: RTL and testbench
====================================

// Module: top_level_hamming
// PURPOSE
//  Top-level Hamming (16,11) SECDED encoder engine. On start, reads 15 11-bit
//  messages from internal data memory, inserts p8/p4/p2/p1 and overall parity p0,
//  and writes 15 16-bit codewords back to the same memory, then raises done.
//  Memory is preloaded and read back hierarchically through instance dm1, array core.
// PARAMETERS
//  NUM_MSG    15   messages per run
//  IN_BASE    0    byte address of first input message
//  OUT_BASE   30   byte address of first output codeword
//  MEM_DEPTH  256  data memory depth, 8-bit bytes
// PORTS
//  clk    in  1  single clock; all state on posedge
//  reset  in  1  synchronous, active-low reset
//  start  in  1  run request; run begins on first clk with start=0 after start=1
//  done   out 1  high when all NUM_MSG codewords are written; held until reset or new start
// BEHAVIOUR
//  - Reset (reset==0 at posedge): FSM->IDLE, msg index=0, done=0. Memory contents NOT cleared.
//  - Input layout, msg i: core[IN_BASE+2i+1]={5'b0,d[11:9]}, core[IN_BASE+2i]=d[8:1]. Bits [7:3] of hi byte ignored.
//  - Parity: p8=^d[11:5]; p4=^d[11:8]^(^d[4:2]);
//    p2=d11^d10^d7^d6^d4^d3^d1; p1=d11^d9^d7^d5^d4^d2^d1;
//    p0=^d[11:1]^p8^p4^p2^p1 (whole 16-bit word has even parity).
//  - Output layout: core[OUT_BASE+2i+1]={d11..d5,p8}; core[OUT_BASE+2i]={d4,d3,d2,p4,d1,p2,p1,p0}.
//  - dm1: single port, combinational read, synchronous write, one access per cycle.
//  - FSM: IDLE -(start seen high, then low)-> RD_LO -> RD_HI -> WR_HI -> WR_LO
//    -> (i==NUM_MSG-1 ? DONE : i++, RD_LO). DONE holds done=1.
//  - Parity logic purely combinational from captured 11-bit message register.
//  - Latency: 4 cycles/message; done rises <= 4*NUM_MSG+4 cycles after run begins.
//  - start during a run: ignored. start=1 in DONE: done=0, back to IDLE-armed.
//  - Reset mid-run: abort immediately; already-written codewords remain, others untouched.
//  - Input region (0..29) never written; bytes >= OUT_BASE+2*NUM_MSG never written.
//  - Address arithmetic 8 bits; no wrap with defaults (max address 59).
// STRUCTURE
//  - Package hamming_pkg: NUM_MSG, IN_BASE, OUT_BASE, MEM_DEPTH defaults; FSM state enum.
//  - Sub-module data_mem, instantiated as dm1, storage array named core[MEM_DEPTH] of 8 bits.
//  - top_level_hamming: FSM, index counter, message register, parity function.
// TESTING
//  - All-zero message: core[1]=0x00,core[0]=0x00 -> core[31]=0x00, core[30]=0x00.
//  - d=0x7FF: core[1]=0x07,core[0]=0xFF -> {core[31],core[30]}=0xFFFF.
//  - d=0x001: core[1]=0x00,core[0]=0x01 -> {core[31],core[30]}=0x000F.
//  - d=0x400: core[1]=0x04,core[0]=0x00 -> {core[31],core[30]}=0x8117.
//  - 15 random messages, reset then start pulse -> done within 64 cycles; all 15
//    codewords at 30..59 match reference model; bytes 0..29 unchanged.
//  - reset low mid-run -> done=0 next cycle, FSM idle; re-start completes fully correct.

Source files
------------

// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hamming_pkg
// Description : Shared defaults, FSM state encoding and the (16,11) SECDED
//               encode function for the Hamming encoder engine.
// Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    localparam int DEF_NUM_MSG   = 15;
    localparam int DEF_IN_BASE   = 0;
    localparam int DEF_OUT_BASE  = 30;
    localparam int DEF_MEM_DEPTH = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_HI = 3'd3,
        ST_WR_LO = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // msg[k-1] holds data bit d<k>; result is {d11..d5,p8,d4,d3,d2,p4,d1,p2,p1,p0}
    function automatic logic [15:0] hamming_encode(input logic [10:0] msg);
        logic p8, p4, p2, p1, p0;
        p8 = ^msg[10:4];
        p4 = (^msg[10:7]) ^ (^msg[3:1]);
        p2 = msg[10] ^ msg[9] ^ msg[6] ^ msg[5] ^ msg[3] ^ msg[2] ^ msg[0];
        p1 = msg[10] ^ msg[8] ^ msg[6] ^ msg[4] ^ msg[3] ^ msg[1] ^ msg[0];
        p0 = (^msg) ^ p8 ^ p4 ^ p2 ^ p1;
        return {msg[10:4], p8, msg[3], msg[2], msg[1], p4, msg[0], p2, p1, p0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// Module      : data_mem
// Description : Single-port byte memory, combinational read, synchronous write.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    // Contents are deliberately not reset; the array is preloaded externally.
    logic [7:0] core [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            core[addr] <= wdata;
        end
    end

    assign rdata = core[addr];

endmodule
`default_nettype wire

// File: rtl/top_level_hamming.sv
`default_nettype none
// ============================================================================
// Module      : top_level_hamming
// Description : Reads NUM_MSG 11-bit messages from dm1, writes back 16-bit
//               SECDED codewords, then raises done.
// Revision    : 1.0 - initial release
// ============================================================================
module top_level_hamming
    import hamming_pkg::*;
#(
    parameter int NUM_MSG   = DEF_NUM_MSG,
    parameter int IN_BASE   = DEF_IN_BASE,
    parameter int OUT_BASE  = DEF_OUT_BASE,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam logic [7:0] C_IN_BASE  = 8'(IN_BASE);
    localparam logic [7:0] C_OUT_BASE = 8'(OUT_BASE);
    localparam logic [7:0] C_LAST_IDX = 8'(NUM_MSG - 1);

    state_t      r_state;
    logic [7:0]  r_idx;
    logic [10:0] r_msg;
    logic        r_armed;
    logic        r_done;

    logic        w_we;
    logic [7:0]  w_addr;
    logic [7:0]  w_wdata;
    logic [7:0]  w_rdata;
    logic [7:0]  w_off;
    logic [15:0] w_cw;

    data_mem #(
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (8)
    ) dm1 (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_addr),
        .wdata (w_wdata),
        .rdata (w_rdata)
    );

    assign w_off = {r_idx[6:0], 1'b0};
    assign w_cw  = hamming_encode(r_msg);

    // Writes are qualified by reset so an abort lands before any further byte.
    always_comb begin
        w_addr  = C_IN_BASE + w_off;
        w_we    = 1'b0;
        w_wdata = w_cw[7:0];
        case (r_state)
            ST_RD_HI: w_addr = C_IN_BASE + w_off + 8'd1;
            ST_WR_HI: begin
                w_addr  = C_OUT_BASE + w_off + 8'd1;
                w_we    = reset;
                w_wdata = w_cw[15:8];
            end
            ST_WR_LO: begin
                w_addr = C_OUT_BASE + w_off;
                w_we   = reset;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_armed <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A run begins on the first low sample following a high one.
                    if (start) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_armed <= 1'b0;
                        r_state <= ST_RD_LO;
                    end
                end
                ST_RD_LO: begin
                    r_msg[7:0] <= w_rdata;
                    r_state    <= ST_RD_HI;
                end
                ST_RD_HI: begin
                    r_msg[10:8] <= w_rdata[2:0];
                    r_state     <= ST_WR_HI;
                end
                ST_WR_HI: r_state <= ST_WR_LO;
                ST_WR_LO: begin
                    if (r_idx == C_LAST_IDX) begin
                        r_idx   <= '0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_state <= ST_RD_LO;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        r_done  <= 1'b0;
                        r_armed <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_top_level_hamming.sv
`default_nettype none
// ============================================================================
// Module      : tb_top_level_hamming
// Description : Self-checking bench for the Hamming (16,11) encoder engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top_level_hamming;

    localparam int N_MSG    = 15;
    localparam int OUT_BASE = 30;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic done;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [10:0] d;
        logic [15:0] cw;
    } vec_t;

    vec_t        vecs [4];
    logic [10:0] msgs [N_MSG];
    logic [7:0]  shadow [64];

    top_level_hamming dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Codeword bit k is Hamming position k: data fills non-power-of-two
    // positions in order, each parity p covers positions having bit p set.
    function automatic logic [15:0] ref_encode(input logic [10:0] d);
        logic [15:0] w;
        logic        b;
        int          k;
        w = '0;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                w[pos] = d[k];
                k++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            b = 1'b0;
            for (int pos = 1; pos < 16; pos++)
                if (((pos & p) != 0) && (pos != p)) b = b ^ w[pos];
            w[p] = b;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mem_cw(input int i);
        return {dut.dm1.core[OUT_BASE + 2*i + 1], dut.dm1.core[OUT_BASE + 2*i]};
    endfunction

    task automatic load_mem(input bit directed);
        logic [4:0] junk;
        for (int i = 0; i < N_MSG; i++) begin
            if (directed && i < 4) begin
                msgs[i] = vecs[i].d;
                junk    = 5'd0;
            end else begin
                msgs[i] = 11'($urandom_range(0, 2047));
                junk    = 5'($urandom_range(0, 31));
            end
            shadow[2*i + 1] = {junk, msgs[i][10:8]};
            shadow[2*i]     = msgs[i][7:0];
        end
        for (int a = 30; a < 64; a++) shadow[a] = 8'($urandom_range(0, 255));
        for (int a = 0; a < 64; a++) dut.dm1.core[a] = shadow[a];
    endtask

    // Waits for done with an optional ignored start pulse at cycle pulse_at.
    task automatic wait_done(input string name, input int pulse_at);
        int cyc;
        cyc = 0;
        while (!done && cyc < 80) begin
            start = (cyc == pulse_at) ? 1'b1 : 1'b0;
            tick();
            cyc++;
        end
        start = 1'b0;
        check({name, "_latency_ok"}, 32'((done === 1'b1) && (cyc <= 64)), 32'd1);
    endtask

    task automatic verify_all(input string name);
        int nbad;
        for (int i = 0; i < N_MSG; i++)
            check($sformatf("%s_cw%0d", name, i), 32'(mem_cw(i)), 32'(ref_encode(msgs[i])));
        nbad = 0;
        for (int a = 0; a < 30; a++) if (dut.dm1.core[a] !== shadow[a]) nbad++;
        check({name, "_input_region_bad"}, 32'(nbad), 32'd0);
        nbad = 0;
        for (int a = 60; a < 64; a++) if (dut.dm1.core[a] !== shadow[a]) nbad++;
        check({name, "_tail_region_bad"}, 32'(nbad), 32'd0);
    endtask

    initial begin
        int nbad;
        vecs[0] = '{11'h000, 16'h0000};
        vecs[1] = '{11'h7FF, 16'hFFFF};
        vecs[2] = '{11'h001, 16'h000F};
        vecs[3] = '{11'h400, 16'h8117};

        reset = 1'b0;
        start = 1'b0;
        tick();
        tick();
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b1;
        tick();
        check("idle_done", 32'(done), 32'd0);

        // Run 1: directed vectors in slots 0..3, random elsewhere.
        load_mem(1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("run1", -1);
        for (int i = 0; i < 4; i++)
            check($sformatf("table_cw%0d", i), 32'(mem_cw(i)), 32'(vecs[i].cw));
        verify_all("run1");
        repeat (5) tick();
        check("done_held", 32'(done), 32'd1);

        // Run 2: start in DONE clears done; a start pulse mid-run is ignored.
        load_mem(1'b0);
        start = 1'b1;
        tick();
        check("done_clear_on_start", 32'(done), 32'd0);
        start = 1'b0;
        wait_done("run2", 20);
        verify_all("run2");

        // Run 3: reset lands while message 5's high byte is about to be written.
        load_mem(1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 23; k++) tick();
        reset = 1'b0;
        tick();
        check("abort_done", 32'(done), 32'd0);
        reset = 1'b1;
        repeat (10) tick();
        check("abort_stays_idle", 32'(done), 32'd0);
        for (int i = 0; i < 5; i++)
            check($sformatf("abort_written_cw%0d", i), 32'(mem_cw(i)), 32'(ref_encode(msgs[i])));
        nbad = 0;
        for (int a = OUT_BASE + 10; a < 64; a++) if (dut.dm1.core[a] !== shadow[a]) nbad++;
        check("abort_untouched_bad", 32'(nbad), 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("run3", -1);
        verify_all("run3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
